// File: rtl/dcache_mem_responder_pkg.sv
// Shared definitions for the DCache main-memory responder: FSM/op encodings and default geometry.
// Optional statistics counters are enabled by DCACHE_MEM_STAT_EN.
package dcache_mem_responder_pkg;

  localparam int LINE_ADDR_LEN_DEF = 3;
  localparam int MEM_ADDR_LEN_DEF  = 9;
  localparam int MEM_LATENCY_DEF   = 50;
  // Wide enough for the largest legal latency (1023).
  localparam int CNT_W             = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } stateT;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } opT;

endpackage

// File: rtl/dcache_mem_responder_if.sv
// Line-refill / write-back bus between the DCache miss logic (master) and the memory responder (slave).
// The statistics outputs exist only when DCACHE_MEM_STAT_EN is defined.
interface dcache_mem_responder_if
  import dcache_mem_responder_pkg::*;
#(
  parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
  parameter int MEM_ADDR_LEN  = MEM_ADDR_LEN_DEF
);
  localparam int LINE_W = 32 << LINE_ADDR_LEN;

  logic                    mem_rd_req;
  logic [MEM_ADDR_LEN-1:0] mem_rd_addr;
  logic [LINE_W-1:0]       mem_rd_line;
  logic                    mem_wr_req;
  logic [MEM_ADDR_LEN-1:0] mem_wr_addr;
  logic [LINE_W-1:0]       mem_wr_line;
  logic                    mem_gnt;
`ifdef DCACHE_MEM_STAT_EN
  logic [31:0]             mem_rd_cnt;
  logic [31:0]             mem_wr_cnt;

  modport master (
    output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_line,
    input  mem_rd_line, mem_gnt, mem_rd_cnt, mem_wr_cnt
  );
  modport slave (
    input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_line,
    output mem_rd_line, mem_gnt, mem_rd_cnt, mem_wr_cnt
  );
`else
  modport master (
    output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_line,
    input  mem_rd_line, mem_gnt
  );
  modport slave (
    input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_line,
    output mem_rd_line, mem_gnt
  );
`endif
endinterface

// File: rtl/dcache_mem_responder_mem_line_array.sv
// Line-wide single-port storage with registered read; deliberately unreset so it maps onto block RAM.
module mem_line_array #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] lines [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      lines[addr] <= wdata;
    end
    rdata <= lines[addr];
  end
endmodule

// File: rtl/dcache_mem_responder.sv
// Fixed-latency main-memory responder for DCache refills and write-backs (req/gnt handshake).
// Define DCACHE_MEM_STAT_EN to add the mem_rd_cnt / mem_wr_cnt completion counters.
module dcache_mem_responder
  import dcache_mem_responder_pkg::*;
#(
  parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
  parameter int MEM_ADDR_LEN  = MEM_ADDR_LEN_DEF,
  parameter int MEM_LATENCY   = MEM_LATENCY_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  dcache_mem_responder_if.slave  memBus
);
  localparam int LINE_W = 32 << LINE_ADDR_LEN;

  stateT                   stateReg, stateNext;
  opT                      opReg, opNext;
  logic [MEM_ADDR_LEN-1:0] addrReg, addrNext;
  logic [LINE_W-1:0]       wrLineReg, wrLineNext;
  logic [LINE_W-1:0]       rdLineReg;
  logic [CNT_W-1:0]        cntReg, cntNext;
  logic [MEM_ADDR_LEN-1:0] arrAddr;
  logic [LINE_W-1:0]       arrRdata;
  logic                    arrWe;
  logic                    lastBusy;
  logic                    gnt;

  assign lastBusy = (stateReg == BUSY) && (cntReg == CNT_W'(MEM_LATENCY - 1));

  always_comb begin
    stateNext  = stateReg;
    opNext     = opReg;
    addrNext   = addrReg;
    wrLineNext = wrLineReg;
    cntNext    = cntReg;
    arrAddr    = addrReg;
    arrWe      = 1'b0;
    gnt        = 1'b0;
    case (stateReg)
      IDLE: begin
        // Present the incoming address so the registered read is valid even for latency 1.
        arrAddr = memBus.mem_wr_req ? memBus.mem_wr_addr : memBus.mem_rd_addr;
        if (memBus.mem_wr_req) begin
          opNext     = OP_WR;
          addrNext   = memBus.mem_wr_addr;
          wrLineNext = memBus.mem_wr_line;
          cntNext    = '0;
          stateNext  = BUSY;
        end else if (memBus.mem_rd_req) begin
          opNext    = OP_RD;
          addrNext  = memBus.mem_rd_addr;
          cntNext   = '0;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        cntNext = cntReg + CNT_W'(1);
        if (lastBusy) begin
          arrWe     = (opReg == OP_WR);
          stateNext = DONE;
        end
      end
      DONE: begin
        gnt       = 1'b1;
        stateNext = RELEASE;
      end
      RELEASE: begin
        // Hold off until the cache drops the request it was granted, so it cannot re-trigger.
        if (opReg == OP_WR ? !memBus.mem_wr_req : !memBus.mem_rd_req) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg  <= IDLE;
      opReg     <= OP_RD;
      addrReg   <= '0;
      wrLineReg <= '0;
      cntReg    <= '0;
      rdLineReg <= '0;
    end else begin
      stateReg  <= stateNext;
      opReg     <= opNext;
      addrReg   <= addrNext;
      wrLineReg <= wrLineNext;
      cntReg    <= cntNext;
      if (lastBusy && opReg == OP_RD) begin
        rdLineReg <= arrRdata;
      end
    end
  end

  mem_line_array #(
    .ADDR_W (MEM_ADDR_LEN),
    .DATA_W (LINE_W)
  ) lineArray (
    .clk   (clk),
    .we    (arrWe),
    .addr  (arrAddr),
    .wdata (wrLineReg),
    .rdata (arrRdata)
  );

  assign memBus.mem_rd_line = rdLineReg;
  assign memBus.mem_gnt     = gnt;

`ifdef DCACHE_MEM_STAT_EN
  logic [31:0] rdCntReg, wrCntReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdCntReg <= '0;
      wrCntReg <= '0;
    end else if (stateReg == DONE) begin
      if (opReg == OP_RD) rdCntReg <= rdCntReg + 32'd1;
      else                wrCntReg <= wrCntReg + 32'd1;
    end
  end

  assign memBus.mem_rd_cnt = rdCntReg;
  assign memBus.mem_wr_cnt = wrCntReg;
`endif
endmodule

// File: tb/tb_dcache_mem_responder.sv
// Scoreboard bench for dcache_mem_responder: directed cases plus randomized traffic against a line-array model.
// Also checks the DCACHE_MEM_STAT_EN counters when that macro is defined.
module tb_dcache_mem_responder;
  localparam int LAT  = 4;
  localparam int LAL  = 3;
  localparam int MAL  = 9;
  localparam int LW   = 32 << LAL;
  localparam int NLIN = 1 << MAL;

  typedef struct {
    bit          isWr;
    int          gntCyc;
    logic [LW-1:0] line;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  expT           sb[$];
  logic [LW-1:0] model [NLIN];
  logic [LW-1:0] modelRd = '0;
  int            expRdCnt = 0;
  int            expWrCnt = 0;

  dcache_mem_responder_if #(.LINE_ADDR_LEN(LAL), .MEM_ADDR_LEN(MAL)) bus ();

  dcache_mem_responder #(
    .LINE_ADDR_LEN (LAL),
    .MEM_ADDR_LEN  (MAL),
    .MEM_LATENCY   (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .memBus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops an expectation on every grant and tracks the value mem_rd_line must hold.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      modelRd  = '0;
      expRdCnt = 0;
      expWrCnt = 0;
      checks++;
      if (bus.mem_gnt !== 1'b0 || bus.mem_rd_line !== '0) begin
        failures++;
        $display("FAIL reset_state: gnt=%b rd_line=%h required gnt=0 rd_line=0", bus.mem_gnt, bus.mem_rd_line);
      end
`ifdef DCACHE_MEM_STAT_EN
      checks++;
      if (bus.mem_rd_cnt !== 32'd0 || bus.mem_wr_cnt !== 32'd0) begin
        failures++;
        $display("FAIL reset_cnt: rd_cnt=%0d wr_cnt=%0d required 0 0", bus.mem_rd_cnt, bus.mem_wr_cnt);
      end
`endif
    end else begin
      if (bus.mem_gnt === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_gnt: gnt=1 at cycle %0d required no grant", cyc);
        end else begin
          expT e;
          e = sb.pop_front();
          if (cyc != e.gntCyc) begin
            failures++;
            $display("FAIL gnt_cycle: got cycle %0d required cycle %0d (%s)", cyc, e.gntCyc, e.isWr ? "write" : "read");
          end
          if (e.isWr) expWrCnt++;
          else begin
            expRdCnt++;
            modelRd = e.line;
          end
        end
      end else if (bus.mem_gnt !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL gnt_value: got %b required 0/1", bus.mem_gnt);
      end
      checks++;
      if (bus.mem_rd_line !== modelRd) begin
        failures++;
        $display("FAIL rd_line: cycle %0d got %h required %h", cyc, bus.mem_rd_line, modelRd);
      end
    end
  end

  function automatic logic [LW-1:0] randLine();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [LW-1:0] rampLine(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  // Waits (bounded) for a grant, holds the request 'hold' extra cycles, then returns one cycle later.
  task automatic waitGnt(input int hold);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * LAT + 20; i++) begin
      @(negedge clk);
      if (bus.mem_gnt === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout: no grant within %0d cycles", 4 * LAT + 20);
    end
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit wr, input bit rd, input logic [MAL-1:0] wa,
                       input logic [MAL-1:0] ra, input logic [LW-1:0] wl, input int hold);
    expT e;
    @(posedge clk);
    #1;
    bus.mem_wr_req  = wr;
    bus.mem_wr_addr = wa;
    bus.mem_wr_line = wl;
    bus.mem_rd_req  = rd;
    bus.mem_rd_addr = ra;
    e.isWr   = wr;
    e.gntCyc = cyc + LAT + 1;
    e.line   = wr ? '0 : model[ra];
    sb.push_back(e);
    if (wr) model[wa] = wl;
    // Inputs are don't-care once accepted; scramble the served side.
    @(posedge clk);
    #1;
    if (wr) begin
      bus.mem_wr_addr = MAL'($urandom());
      bus.mem_wr_line = randLine();
    end else begin
      bus.mem_rd_addr = MAL'($urandom());
    end
    waitGnt(hold);
    if (wr) bus.mem_wr_req = 1'b0;
    else    bus.mem_rd_req = 1'b0;
    if (wr && rd) begin
      e.isWr   = 1'b0;
      e.gntCyc = cyc + 1 + LAT + 1;
      e.line   = model[ra];
      sb.push_back(e);
      waitGnt(hold);
      bus.mem_rd_req = 1'b0;
    end
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    bus.mem_rd_req = 1'b0;
    bus.mem_wr_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    expT e;
    logic [LW-1:0] oldNine;
    bus.mem_rd_req  = 1'b0;
    bus.mem_wr_req  = 1'b0;
    bus.mem_rd_addr = '0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_line = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Preload every line so all later reads have a known expectation.
    for (int a = 0; a < NLIN; a++) begin
      issue(1'b1, 1'b0, MAL'(a), '0, (a == 5) ? rampLine(32'h1000) : randLine(), 0);
    end

    // Read after reset: grant exactly LAT+1 cycles after the request.
    pulseReset();
    issue(1'b0, 1'b1, '0, MAL'(5), '0, 0);

    // Write then read back the same line.
    issue(1'b1, 1'b0, MAL'(7), '0, rampLine(32'h000000A0), 0);
    issue(1'b0, 1'b1, '0, MAL'(7), '0, 0);

    // Simultaneous write and read to line 2: write first, read afterwards sees new data.
    issue(1'b1, 1'b1, MAL'(2), MAL'(2), randLine(), 0);

    // Request held 3 cycles past grant must not re-trigger.
    issue(1'b0, 1'b1, '0, MAL'(5), '0, 3);
    issue(1'b1, 1'b0, MAL'(11), '0, randLine(), 3);

    // Request dropped before grant still completes.
    @(posedge clk);
    #1;
    bus.mem_rd_req  = 1'b1;
    bus.mem_rd_addr = MAL'(7);
    e.isWr   = 1'b0;
    e.gntCyc = cyc + LAT + 1;
    e.line   = model[7];
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.mem_rd_req = 1'b0;
    waitGnt(0);

    // Reset during BUSY of a write to line 9: aborted, line keeps its old data.
    oldNine = model[9];
    @(posedge clk);
    #1;
    bus.mem_wr_req  = 1'b1;
    bus.mem_wr_addr = MAL'(9);
    bus.mem_wr_line = ~oldNine;
    repeat (2) @(posedge clk);
    #1;
    rst            = 1'b1;
    bus.mem_wr_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1'b0, 1'b1, '0, MAL'(9), '0, 0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      issue(kind != 1, kind != 0, MAL'($urandom()), MAL'($urandom()), randLine(),
            int'($urandom_range(0, 3)));
    end

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d grants outstanding required 0", sb.size());
    end
`ifdef DCACHE_MEM_STAT_EN
    checks++;
    if (bus.mem_rd_cnt !== 32'(expRdCnt) || bus.mem_wr_cnt !== 32'(expWrCnt)) begin
      failures++;
      $display("FAIL stat_cnt: rd_cnt=%0d wr_cnt=%0d required %0d %0d",
               bus.mem_rd_cnt, bus.mem_wr_cnt, expRdCnt, expWrCnt);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
